// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: default widths,
// instruction field positions and opcode encodings.
package instr_fetch_unit_pkg;

    localparam int unsigned PC_W_DEF    = 4;
    localparam int unsigned INSTR_W_DEF = 16;
    localparam int unsigned DEPTH_DEF   = 4;

    localparam int unsigned OPC_HI  = 15;
    localparam int unsigned OPC_LO  = 12;
    localparam int unsigned DST_HI  = 11;
    localparam int unsigned DST_LO  = 8;
    localparam int unsigned SRC1_HI = 7;
    localparam int unsigned SRC1_LO = 4;
    localparam int unsigned SRC2_HI = 3;
    localparam int unsigned SRC2_LO = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_LOAD = 4'b0011
    } opcode_e;

    function automatic logic [3:0] get_opcode(input logic [INSTR_W_DEF-1:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Prefetch FIFO holding {pc, instr} entries; head is presented without
// an output register, and reads as zero while empty.
module fetch_queue #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && !flush;

    assign head_data = empty ? '0 : mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full && !flush))
        else $error("fetch_queue: push into full queue");

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: fetch PC, request credit and one-deep
// in-flight tracking in front of a prefetch queue.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned PC_W    = PC_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    input  logic               out_ready
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]  fetch_pc;
    logic             infl_valid;
    logic [PC_W-1:0]  infl_pc;
    logic [CNT_W-1:0] q_count;
    logic             q_full;
    logic             q_empty;
    logic             credit;
    logic             push;
    logic             pop;

    // Credit counts the in-flight word so the queue can never overflow;
    // a same-cycle pop is deliberately not credited.
    assign credit    = (q_count + CNT_W'(infl_valid)) < CNT_W'(DEPTH);
    assign imem_req  = !rst && !redirect_valid && credit && !q_full;
    assign imem_addr = fetch_pc;

    assign push      = infl_valid && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign out_valid = !q_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc   <= '0;
            infl_valid <= 1'b0;
            infl_pc    <= '0;
        end else begin
            infl_valid <= imem_req;
            if (imem_req) begin
                infl_pc <= fetch_pc;
            end
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end else if (imem_req) begin
                fetch_pc <= fetch_pc + PC_W'(1);
            end
        end
    end

    fetch_queue #(
        .WIDTH (PC_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({infl_pc, imem_rdata}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data ({out_pc, out_instr}),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

endmodule
